// File: rtl/pingpong_sp_ram_pkg.sv
// Shared helpers for the ping-pong sample capture block.
// Address width derivation for the bank pointers.
package pingpong_sp_ram_pkg;

  function automatic int addr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pingpong_sp_ram_sp_ram.sv
// Single-port RAM bank with registered read.
// Read register clears on reset; the array itself does not.
module sp_ram
  import pingpong_sp_ram_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 10,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read, held while not enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/pingpong_sp_ram.sv
// Ping-pong capture: one bank fills while the other
// streams out one word per cycle.
module pingpong_sp_ram
  import pingpong_sp_ram_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] sample_i,
  input  logic             sample_ready_i,
  output logic [WIDTH-1:0] read_data_o,
  output logic             buffer_ready_o
);

  localparam int AW = addr_w(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic          wr_bank;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rd_active;
  logic          rd_sel;
  logic          frame_done;

  logic             we0, we1;
  logic             re0, re1;
  logic [AW-1:0]    addr0, addr1;
  logic [WIDTH-1:0] rdata0, rdata1;

  assign frame_done = sample_ready_i && (wr_ptr == LAST);

  // Fill pointer and bank swap on the last sample
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      wr_bank <= 1'b0;
    end else if (sample_ready_i) begin
      if (wr_ptr == LAST) begin
        wr_ptr  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // Readout sequencer; a new frame restarts it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr    <= '0;
      rd_active <= 1'b0;
      rd_sel    <= 1'b0;
    end else begin
      if (rd_active) begin
        rd_sel <= ~wr_bank;
        if (rd_ptr == LAST) begin
          rd_ptr    <= '0;
          rd_active <= 1'b0;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
      if (frame_done) begin
        rd_ptr    <= '0;
        rd_active <= 1'b1;
      end
    end
  end

  // One-cycle frame-complete pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buffer_ready_o <= 1'b0;
    end else begin
      buffer_ready_o <= frame_done;
    end
  end

  // Bank port steering: write bank gets wr_ptr, other gets rd_ptr
  always_comb begin
    we0   = sample_ready_i & ~wr_bank;
    we1   = sample_ready_i & wr_bank;
    re0   = rd_active & wr_bank;
    re1   = rd_active & ~wr_bank;
    addr0 = wr_ptr;
    addr1 = rd_ptr;
    if (wr_bank) begin
      addr0 = rd_ptr;
      addr1 = wr_ptr;
    end
  end

  // Present the bank that was read most recently
  always_comb begin
    read_data_o = rdata0;
    unique case (1'b1)
      rd_sel:  read_data_o = rdata1;
      default: read_data_o = rdata0;
    endcase
  end

  sp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank0 (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (we0),
    .re    (re0),
    .addr  (addr0),
    .wdata (sample_i),
    .rdata (rdata0)
  );

  sp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank1 (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (we1),
    .re    (re1),
    .addr  (addr1),
    .wdata (sample_i),
    .rdata (rdata1)
  );

endmodule

// File: tb/tb_pingpong_sp_ram.sv
// Bench for pingpong_sp_ram: directed frames plus random
// strobes against a frame-level queue model.
module tb_pingpong_sp_ram;

  localparam int WIDTH = 16;
  localparam int DEPTH = 10;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] sample;
  logic             sample_ready;
  logic [WIDTH-1:0] read_data;
  logic             buffer_ready;

  int chk_cnt;
  int pass_cnt;
  int obs_pulses;

  logic [WIDTH-1:0] fill_q[$];
  logic [WIDTH-1:0] rd_q[$];
  logic [WIDTH-1:0] exp_data;
  logic             exp_pulse;

  pingpong_sp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .sample_i       (sample),
    .sample_ready_i (sample_ready),
    .read_data_o    (read_data),
    .buffer_ready_o (buffer_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    fill_q.delete();
    rd_q.delete();
    exp_data  = '0;
    exp_pulse = 1'b0;
  endtask

  // Frame-level behaviour at one rising edge
  task automatic model_edge(input logic v,
                            input logic [WIDTH-1:0] d);
    exp_pulse = 1'b0;
    if (rd_q.size() > 0) exp_data = rd_q.pop_front();
    if (v) begin
      fill_q.push_back(d);
      if (fill_q.size() == DEPTH) begin
        exp_pulse = 1'b1;
        rd_q = fill_q;
        fill_q.delete();
      end
    end
  endtask

  task automatic step(input logic v, input logic [WIDTH-1:0] d);
    @(negedge clk);
    sample_ready = v;
    sample = d;
    @(posedge clk);
    model_edge(v, d);
    #1;
    if (buffer_ready) obs_pulses++;
    chk("data", 32'(read_data), 32'(exp_data));
    chk("pulse", 32'(buffer_ready), 32'(exp_pulse));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'hDEAD);
  endtask

  task automatic frame(input logic [WIDTH-1:0] base);
    for (int i = 0; i < DEPTH; i++) step(1'b1, base + 16'(i));
  endtask

  initial begin
    int p0;
    chk_cnt = 0;
    pass_cnt = 0;
    obs_pulses = 0;
    rst = 1'b1;
    sample = '0;
    sample_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_data", 32'(read_data), 32'h0);
    chk("rst_pulse", 32'(buffer_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // single frame, then drain and hold
    frame(16'hA000);
    idle(DEPTH + 3);

    // three frames with short gaps
    p0 = obs_pulses;
    for (int f = 0; f < 3; f++) begin
      frame(16'hA000 + 16'(f * 256));
      idle(3);
    end
    idle(DEPTH);
    chk("three_pulses", 32'(obs_pulses - p0), 32'd3);

    // frame split by a long gap
    p0 = obs_pulses;
    for (int i = 0; i < 5; i++) step(1'b1, 16'hC000 + 16'(i));
    idle(20);
    for (int i = 5; i < 10; i++) step(1'b1, 16'hC000 + 16'(i));
    idle(DEPTH + 1);
    chk("gap_pulse", 32'(obs_pulses - p0), 32'd1);

    // reset with a partial frame in flight
    for (int i = 0; i < 6; i++) step(1'b1, 16'hE000 + 16'(i));
    @(negedge clk);
    sample_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_data", 32'(read_data), 32'h0);
    chk("mid_rst_pulse", 32'(buffer_ready), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    p0 = obs_pulses;
    frame(16'hB000);
    idle(DEPTH + 1);
    chk("post_rst_pulse", 32'(obs_pulses - p0), 32'd1);

    // back-to-back frames
    p0 = obs_pulses;
    for (int i = 0; i < 30; i++) step(1'b1, 16'h5000 + 16'(i));
    idle(DEPTH + 1);
    chk("b2b_pulses", 32'(obs_pulses - p0), 32'd3);

    // random strobes and data
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 16'($urandom));
    end
    idle(DEPTH + 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
